// File: rtl/vcd_vector_encoder_pkg.sv
// Shared constants and state type for the VCD value-change record encoder.
// Holds the ASCII bytes that make up a record and the FSM state encoding.
package vcd_enc_pkg;

  localparam logic [7:0] ASC_B  = 8'h62;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_1  = 8'h31;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_NL = 8'h0A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREFIX = 3'd1,
    BITS   = 3'd2,
    SPACE  = 3'd3,
    ID     = 3'd4,
    NL     = 3'd5
  } enc_state_t;

endpackage

// File: rtl/vcd_msb_index.sv
// Combinational index of the highest set bit of a vector; a zero value yields 0.
// Sets the starting bit position so leading zeros are never emitted.
module vcd_msb_index #(
  parameter  int WIDTH = 128,
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [IW-1:0]    msb
);

  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) msb = IW'(i);
    end
  end

endmodule

// File: rtl/vcd_vector_encoder.sv
// Per-signal VCD encoder: turns a changed (or forced) sample into the ASCII
// record "b<bits> <id>\n" (vector) or "<bit><id>\n" (WIDTH==1), one byte per handshake.
module vcd_vector_encoder
  import vcd_enc_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int ID_CHARS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*ID_CHARS-1:0] id_code,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_force,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic [2:0]            dbg_state
);

  localparam int         IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] ID_LAST = 2'(ID_CHARS - 1);
  localparam bit         SCALAR  = (WIDTH == 1);

  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high at the rising clock edge; valid never waits on ready, and a source
  // holding valid keeps its payload stable until the transfer.
  enc_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             has_prev_q, has_prev_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [1:0]       id_idx_q, id_idx_d;
  logic [IW-1:0]    msb;
  logic [WIDTH-1:0] bit_sh;
  logic             cur_bit;
  logic [7:0]       id_byte;
  logic             accept;
  logic             emit;
  logic             fire;

  vcd_msb_index #(.WIDTH(WIDTH)) u_msb (
    .value (in_value),
    .msb   (msb)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign fire      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign emit      = accept && (!has_prev_q || in_force || (in_value != prev_q));
  assign dbg_state = state_q;

  // The latched sample doubles as the previous value for change detection.
  assign bit_sh  = prev_q >> cnt_q;
  assign cur_bit = bit_sh[0];

  always_comb begin
    id_byte = 8'h00;
    for (int k = 0; k < ID_CHARS; k++) begin
      if (id_idx_q == 2'(k)) id_byte = id_code[8*(ID_CHARS-1-k) +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    cnt_d      = cnt_q;
    id_idx_d   = id_idx_q;
    out_data   = 8'h00;
    out_last   = 1'b0;
    case (state_q)
      IDLE: begin
        id_idx_d = '0;
        if (emit) begin
          prev_d     = in_value;
          has_prev_d = 1'b1;
          cnt_d      = msb;
          state_d    = SCALAR ? BITS : PREFIX;
        end
      end
      PREFIX: begin
        out_data = ASC_B;
        if (fire) state_d = BITS;
      end
      BITS: begin
        out_data = cur_bit ? ASC_1 : ASC_0;
        if (fire) begin
          if (cnt_q == '0) state_d = SCALAR ? ID : SPACE;
          else             cnt_d   = cnt_q - IW'(1);
        end
      end
      SPACE: begin
        out_data = ASC_SP;
        if (fire) state_d = ID;
      end
      ID: begin
        out_data = id_byte;
        if (fire) begin
          if (id_idx_q == ID_LAST) state_d  = NL;
          else                     id_idx_d = id_idx_q + 2'd1;
        end
      end
      NL: begin
        out_data = ASC_NL;
        out_last = 1'b1;
        if (fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      has_prev_q <= 1'b0;
      cnt_q      <= '0;
      id_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      has_prev_q <= has_prev_d;
      cnt_q      <= cnt_d;
      id_idx_q   <= id_idx_d;
    end
  end

endmodule
